// File: rtl/bus_arbiter_mux.sv
// bus_arbiter_mux: round-robin arbiter FSM plus registered data mux onto one shared bus.
// Latency: grant 1 cycle after first sampled request, bus_data 1 cycle after grant.
// No backpressure; the owner holds while requesting. BUS_TIMEOUT_EN bounds the hold to HOLD_MAX cycles.
module bus_arbiter_mux #(
    parameter int NUM_M    = 2,
    parameter int WIDTH    = 32,
    parameter int HOLD_MAX = 4,
    localparam int IDW     = (NUM_M > 2) ? $clog2(NUM_M) : 1
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NUM_M-1:0]       m_req,
    input  logic [NUM_M*WIDTH-1:0] m_data,
    output logic [NUM_M-1:0]       m_grant,
    output logic [IDW-1:0]         grant_id,
    output logic [WIDTH-1:0]       bus_data,
    output logic                   bus_valid
);

    if (NUM_M < 2 || NUM_M > 8 || HOLD_MAX < 1) begin : g_param_check
        $error("bus_arbiter_mux: NUM_M must be 2..8 and HOLD_MAX >= 1");
    end

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [IDW-1:0]   last;
    logic [IDW-1:0]   pick_id;
    logic [IDW-1:0]   gid_nxt;
    logic [NUM_M-1:0] grant_nxt;
    logic             pick_vld;
    logic             take;
    logic             owner_req;
    logic             expire;

    // Scan from farthest to nearest so the requester closest after last wins.
    always_comb begin
        logic [IDW-1:0] cand;
        cand     = '0;
        pick_id  = '0;
        pick_vld = 1'b0;
        for (int i = NUM_M; i >= 1; i--) begin
            cand = IDW'((int'(last) + i) % NUM_M);
            if (m_req[cand]) begin
                pick_id  = cand;
                pick_vld = 1'b1;
            end
        end
    end

    assign owner_req = m_req[grant_id];

`ifdef BUS_TIMEOUT_EN
    localparam int HCW = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    logic [HCW-1:0] hold_cnt;

    assign expire = (hold_cnt == HCW'(HOLD_MAX - 1)) && (|(m_req & ~m_grant));

    always_ff @(posedge clk) begin
        if (reset || take || state_nxt == IDLE) begin
            hold_cnt <= '0;
        end else if (hold_cnt != HCW'(HOLD_MAX - 1)) begin
            hold_cnt <= hold_cnt + 1'b1;
        end
    end
`else
    assign expire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            m_grant  <= '0;
            grant_id <= '0;
            last     <= IDW'(NUM_M - 1);
        end else begin
            state    <= state_nxt;
            m_grant  <= grant_nxt;
            grant_id <= gid_nxt;
            if (take) begin
                last <= pick_id;
            end
        end
    end

    always_comb begin
        state_nxt = state;
        take      = 1'b0;
        case (state)
            IDLE: begin
                if (|m_req) begin
                    state_nxt = GRANT;
                    take      = 1'b1;
                end
            end
            GRANT: begin
                if (!owner_req || expire) begin
                    if (pick_vld) begin
                        take = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        grant_nxt = m_grant;
        gid_nxt   = grant_id;
        if (take) begin
            grant_nxt          = '0;
            grant_nxt[pick_id] = 1'b1;
            gid_nxt            = pick_id;
        end else if (state_nxt == IDLE) begin
            grant_nxt = '0;
        end
    end

    // Data follows the grant registered on the previous edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bus_data  <= '0;
            bus_valid <= 1'b0;
        end else if (|m_grant) begin
            bus_data  <= m_data[int'(grant_id)*WIDTH +: WIDTH];
            bus_valid <= 1'b1;
        end else begin
            bus_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: a 2-master and a 3-master instance, per-scenario tasks,
// bus words predicted into queues when a grant is expected and popped when bus_valid appears.
module tb_bus_arbiter_mux;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [1:0]  req2;
    logic [63:0] data2;
    logic [1:0]  m_grant2;
    logic [0:0]  gid2;
    logic [31:0] bus_data2;
    logic        bus_valid2;

    logic [2:0]  req3;
    logic [95:0] data3;
    logic [2:0]  m_grant3;
    logic [1:0]  gid3;
    logic [31:0] bus_data3;
    logic        bus_valid3;

    int tests = 0;
    int fails = 0;
    logic [31:0] q2[$];
    logic [31:0] q3[$];

    bus_arbiter_mux #(.NUM_M(2), .WIDTH(32), .HOLD_MAX(4)) u_dut2 (
        .clk(clk), .reset(reset), .m_req(req2), .m_data(data2),
        .m_grant(m_grant2), .grant_id(gid2), .bus_data(bus_data2), .bus_valid(bus_valid2)
    );

    bus_arbiter_mux #(.NUM_M(3), .WIDTH(32), .HOLD_MAX(4)) u_dut3 (
        .clk(clk), .reset(reset), .m_req(req3), .m_data(data3),
        .m_grant(m_grant3), .grant_id(gid3), .bus_data(bus_data3), .bus_valid(bus_valid3)
    );

    function automatic int oh_idx(input logic [7:0] g);
        int k;
        k = 0;
        for (int i = 0; i < 8; i++) if (g[i]) k = i;
        return k;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req2  = 2'b11;
        req3  = 3'b000;
        data2 = {32'h5a5a_5a5a, 32'ha5a5_a5a5};
        data3 = '0;
        repeat (2) step();
        tests++; if (m_grant2 !== 2'b00) begin fails++; $display("FAIL reset_grant: got %b want 00", m_grant2); end
        tests++; if (gid2 !== 1'b0) begin fails++; $display("FAIL reset_gid: got %0d want 0", gid2); end
        tests++; if (bus_data2 !== 32'h0) begin fails++; $display("FAIL reset_data: got %h want 0", bus_data2); end
        tests++; if (bus_valid2 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus_valid2); end
        tests++; if (m_grant3 !== 3'b000 || bus_valid3 !== 1'b0) begin
            fails++; $display("FAIL reset_dut3: got %b/%b want 000/0", m_grant3, bus_valid3);
        end
        q2.delete();
        q3.delete();
        reset = 1'b0;
        step();
        tests++; if (m_grant2 !== 2'b01 || gid2 !== 1'b0) begin
            fails++; $display("FAIL release_grant: got %b/%0d want 01/0", m_grant2, gid2);
        end
        req2 = 2'b00;
        step();
        tests++; if (m_grant2 !== 2'b00) begin fails++; $display("FAIL release_drop: got %b want 00", m_grant2); end
        tests++; if (bus_valid2 !== 1'b1 || bus_data2 !== 32'ha5a5_a5a5) begin
            fails++; $display("FAIL release_bus: got %b/%h want 1/a5a5a5a5", bus_valid2, bus_data2);
        end
        step();
        tests++; if (bus_valid2 !== 1'b0) begin fails++; $display("FAIL release_idle: got %b want 0", bus_valid2); end
    endtask

    task automatic test_single_master();
        logic [1:0]  rq [4];
        logic [1:0]  eg [4];
        logic [31:0] exp;
        int          k;
        rq = '{2'b10, 2'b10, 2'b00, 2'b00};
        eg = '{2'b10, 2'b10, 2'b00, 2'b00};
        data2 = {32'hffff_ffff, 32'h0000_0000};
        for (int i = 0; i < 4; i++) begin
            req2 = rq[i];
            step();
            k = oh_idx(8'(eg[i]));
            tests++;
            if (m_grant2 !== eg[i] || (eg[i] != 2'b00 && gid2 !== k[0:0])) begin
                fails++; $display("FAIL single_grant cyc %0d: got %b/%0d want %b/%0d", i, m_grant2, gid2, eg[i], k);
            end
            tests++;
            if (q2.size() != 0) begin
                exp = q2.pop_front();
                if (bus_valid2 !== 1'b1 || bus_data2 !== exp) begin
                    fails++; $display("FAIL single_bus cyc %0d: got %b/%h want 1/%h", i, bus_valid2, bus_data2, exp);
                end
            end else if (bus_valid2 !== 1'b0) begin
                fails++; $display("FAIL single_bus cyc %0d: got valid %b want 0", i, bus_valid2);
            end
            if (eg[i] != 2'b00) q2.push_back(data2[k*32 +: 32]);
        end
        tests++; if (bus_data2 !== 32'hffff_ffff) begin
            fails++; $display("FAIL single_hold: got %h want ffffffff", bus_data2);
        end
    endtask

    task automatic test_handover();
        logic [1:0]  rq [5];
        logic [1:0]  eg [5];
        logic [31:0] exp;
        int          k;
        rq = '{2'b01, 2'b11, 2'b10, 2'b00, 2'b00};
        eg = '{2'b01, 2'b01, 2'b10, 2'b00, 2'b00};
        data2 = {32'h9999_5959, 32'h1234_1234};
        for (int i = 0; i < 5; i++) begin
            req2 = rq[i];
            step();
            k = oh_idx(8'(eg[i]));
            tests++;
            if (m_grant2 !== eg[i] || (eg[i] != 2'b00 && gid2 !== k[0:0])) begin
                fails++; $display("FAIL handover_grant cyc %0d: got %b/%0d want %b/%0d", i, m_grant2, gid2, eg[i], k);
            end
            tests++;
            if (q2.size() != 0) begin
                exp = q2.pop_front();
                if (bus_valid2 !== 1'b1 || bus_data2 !== exp) begin
                    fails++; $display("FAIL handover_bus cyc %0d: got %b/%h want 1/%h", i, bus_valid2, bus_data2, exp);
                end
            end else if (bus_valid2 !== 1'b0) begin
                fails++; $display("FAIL handover_bus cyc %0d: got valid %b want 0", i, bus_valid2);
            end
            if (eg[i] != 2'b00) q2.push_back(data2[k*32 +: 32]);
        end
    endtask

    task automatic test_mid_reset();
        logic [31:0] exp;
        data2 = {32'h7777_7333, 32'h0000_0000};
        for (int i = 0; i < 2; i++) begin
            req2 = 2'b10;
            step();
            tests++; if (m_grant2 !== 2'b10 || gid2 !== 1'b1) begin
                fails++; $display("FAIL midrst_grant cyc %0d: got %b/%0d want 10/1", i, m_grant2, gid2);
            end
            tests++;
            if (q2.size() != 0) begin
                exp = q2.pop_front();
                if (bus_valid2 !== 1'b1 || bus_data2 !== exp) begin
                    fails++; $display("FAIL midrst_bus cyc %0d: got %b/%h want 1/%h", i, bus_valid2, bus_data2, exp);
                end
            end else if (bus_valid2 !== 1'b0) begin
                fails++; $display("FAIL midrst_bus cyc %0d: got valid %b want 0", i, bus_valid2);
            end
            q2.push_back(data2[63:32]);
        end
        reset = 1'b1;
        req2  = 2'b11;
        step();
        q2.delete();
        tests++; if (m_grant2 !== 2'b00 || bus_valid2 !== 1'b0 || bus_data2 !== 32'h0) begin
            fails++; $display("FAIL midrst_edge: got %b/%b/%h want 00/0/00000000", m_grant2, bus_valid2, bus_data2);
        end
        reset = 1'b0;
        step();
        tests++; if (m_grant2 !== 2'b01 || gid2 !== 1'b0) begin
            fails++; $display("FAIL midrst_restart: got %b/%0d want 01/0", m_grant2, gid2);
        end
    endtask

    task automatic test_timeout();
        logic [1:0]  eg;
        logic [31:0] exp;
        int          k;
        reset = 1'b1;
        req2  = 2'b00;
        step();
        reset = 1'b0;
        q2.delete();
        data2 = {32'hbbbb_0001, 32'haaaa_0000};
        for (int i = 0; i < 16; i++) begin
            req2 = 2'b11;
            step();
`ifdef BUS_TIMEOUT_EN
            eg = (((i / 4) % 2) == 0) ? 2'b01 : 2'b10;
`else
            eg = 2'b01;
`endif
            k = oh_idx(8'(eg));
            tests++;
            if (m_grant2 !== eg || gid2 !== k[0:0]) begin
                fails++; $display("FAIL timeout_grant cyc %0d: got %b/%0d want %b/%0d", i, m_grant2, gid2, eg, k);
            end
            tests++;
            if (q2.size() != 0) begin
                exp = q2.pop_front();
                if (bus_valid2 !== 1'b1 || bus_data2 !== exp) begin
                    fails++; $display("FAIL timeout_bus cyc %0d: got %b/%h want 1/%h", i, bus_valid2, bus_data2, exp);
                end
            end else if (bus_valid2 !== 1'b0) begin
                fails++; $display("FAIL timeout_bus cyc %0d: got valid %b want 0", i, bus_valid2);
            end
            q2.push_back(data2[k*32 +: 32]);
        end
        req2 = 2'b00;
        repeat (2) step();
        q2.delete();
    endtask

    task automatic test_fairness();
        logic [2:0]  eg;
        logic [31:0] exp;
        int          k;
        data3 = {32'h3333_0002, 32'h2222_0001, 32'h1111_0000};
        for (int r = 0; r < 12; r++) begin
            req3 = ((r % 2) == 0) ? 3'b111 : 3'b000;
            step();
            k  = (r / 2) % 3;
            eg = ((r % 2) == 0) ? 3'(1 << k) : 3'b000;
            tests++;
            if (m_grant3 !== eg || gid3 !== k[1:0]) begin
                fails++; $display("FAIL fair_grant cyc %0d: got %b/%0d want %b/%0d", r, m_grant3, gid3, eg, k);
            end
            tests++;
            if (q3.size() != 0) begin
                exp = q3.pop_front();
                if (bus_valid3 !== 1'b1 || bus_data3 !== exp) begin
                    fails++; $display("FAIL fair_bus cyc %0d: got %b/%h want 1/%h", r, bus_valid3, bus_data3, exp);
                end
            end else if (bus_valid3 !== 1'b0) begin
                fails++; $display("FAIL fair_bus cyc %0d: got valid %b want 0", r, bus_valid3);
            end
            if (eg != 3'b000) q3.push_back(data3[k*32 +: 32]);
        end
    endtask

    initial begin
        test_reset();
        test_single_master();
        test_handover();
        test_mid_reset();
        test_timeout();
        test_fairness();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, tests %0d failed %0d", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/bus_arbiter_mux.md
Name: bus_arbiter_mux

Overview:
- Parametrised successor to the team's 2:1 32-bit bus mux.
- Connects NUM_M masters to one shared bus.
- A round-robin arbiter FSM selects one master; a registered WIDTH-bit data mux drives the bus from that master.
- Sits between the master ports and the shared slave-side bus, in place of the static select-driven mux.

Parameters:
- NUM_M, 2, number of masters; legal range 2..8, need not be a power of two.
- WIDTH, 32, data width per master.
- HOLD_MAX, 4, maximum consecutive grant cycles; used only when BUS_TIMEOUT_EN is defined; must be >= 1.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- m_req  input  NUM_M  request per master; bit i belongs to master i.
- m_data  input  NUM_M*WIDTH  flattened master data; master i occupies bits [i*WIDTH +: WIDTH].
- m_grant  output  NUM_M  one-hot grant, registered.
- grant_id  output  IDW  index of the granted master, registered; IDW = max(1, clog2(NUM_M)).
- bus_data  output  WIDTH  registered bus data.
- bus_valid  output  1  bus_data holds the granted master's data.

Behaviour:
- Clock, reset and update rules:
  - One clock (clk); reset is synchronous and active-high.
  - All outputs are registered; there is no combinational path from any input to any output.
- Reset values, applied on the edge where reset = 1:
  - state = IDLE, m_grant = 0, grant_id = 0, bus_data = 0, bus_valid = 0.
  - Round-robin pointer last = NUM_M-1, so master 0 has highest priority first.
  - hold_cnt = 0.
- Reset mid-operation: the grant drops on that same edge. No partial transfer is flagged.
- Round-robin pick: the first requesting index found by searching last+1, last+2, ... modulo NUM_M (wrap-around).
- IDLE state:
  - m_req == 0: stay in IDLE.
  - Otherwise: on the edge, m_grant = one-hot(pick), grant_id = pick, last = pick, go to GRANT.
  - Grant latency is 1 cycle from the first sampled request.
- GRANT state, owner = grant_id:
  - m_req[owner] = 1: hold the grant. Other requests are ignored (no preemption).
  - m_req[owner] = 0 and another request pending: hand over on the same edge to the next round-robin pick. No idle cycle.
  - m_req[owner] = 0 and no request pending: m_grant = 0, go to IDLE. grant_id keeps its last value.
- Data path:
  - Each edge where m_grant != 0 (the registered value before the edge): bus_data = m_data slice for grant_id, bus_valid = 1.
  - Otherwise bus_valid = 0 and bus_data holds its value.
  - Bus data therefore lags the grant by 1 cycle.
  - Data is passed unmodified; there is no width conversion.
- Simultaneous requests: the round-robin order alone decides; there is no fixed priority after reset.
- NUM_M not a power of two: pointer and pick wrap at NUM_M. Unused grant_id codes never appear.
- Invariant: m_grant is always zero or one-hot.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - hold_cnt counts GRANT cycles for the current owner.
  - It resets to 0 on every new grant, on the return to IDLE, and on reset.
  - When hold_cnt == HOLD_MAX-1 and any other master requests, the grant moves to the next round-robin pick on that edge, even if the owner still requests.
  - With no other requester the owner keeps the grant and hold_cnt saturates.
- Not defined:
  - No hold_cnt register.
  - The owner keeps the grant indefinitely while its request is asserted.
  - HOLD_MAX is ignored.

Test Plan:
- Reset: assert reset 2 cycles with m_req = 2'b11 -> m_grant = 0, grant_id = 0, bus_data = 0, bus_valid = 0. Release -> m_grant = 2'b01 one edge later.
- Single master (NUM_M = 2): m_data1 = 32'hffffffff, m_req = 2'b10 -> m_grant = 2'b10 after 1 cycle. bus_data = 32'hffffffff, bus_valid = 1 after 2 cycles. Drop req -> m_grant = 0 next edge, bus_valid = 0 the edge after.
- Handover: master 0 holds with m_data0 = 32'h12341234 while master 1 requests with m_data1 = 32'h99995959; drop m_req[0] -> m_grant goes 01 to 10 on one edge with no gap. bus_data goes 32'h12341234 then 32'h99995959.
- Fairness (NUM_M = 3): all requests pulsed one cycle after each grant -> grant order 0,1,2,0,1,2. Pointer wraps from index 2 to 0.
- Mid-operation reset: pulse reset while master 1 is granted and bus_data = 32'h77777333 -> grant 0 and bus_valid 0 at that edge. Next pick starts at master 0.
- BUS_TIMEOUT_EN, HOLD_MAX = 4: both requests held high -> each master gets exactly 4 grant cycles, alternating 0,1,0,1. Without the macro, master 0 holds indefinitely.
